// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 Set-2 keyboard event decoder:
// parser states, event record, prefix bytes, modifier/lock key codes.
package ps2_kbd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GOT_E0,
    ST_GOT_F0,
    ST_GOT_E0F0,
    ST_PAUSE_SKIP
  } parser_state_t;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } kbd_event_t;

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam logic [7:0] BYTE_E1 = 8'hE1;

  localparam logic [7:0] CODE_SHIFT_L = 8'h12;
  localparam logic [7:0] CODE_SHIFT_R = 8'h59;
  localparam logic [7:0] CODE_CTRL    = 8'h14;
  localparam logic [7:0] CODE_ALT     = 8'h11;
  localparam logic [7:0] CODE_GUI_L   = 8'h1F;
  localparam logic [7:0] CODE_GUI_R   = 8'h27;
  localparam logic [7:0] CODE_CAPS    = 8'h58;
  localparam logic [7:0] CODE_NUM     = 8'h77;
  localparam logic [7:0] CODE_SCROLL  = 8'h7E;

  localparam logic [2:0] MOD_LSHIFT = 3'd0;
  localparam logic [2:0] MOD_RSHIFT = 3'd1;
  localparam logic [2:0] MOD_LCTRL  = 3'd2;
  localparam logic [2:0] MOD_RCTRL  = 3'd3;
  localparam logic [2:0] MOD_LALT   = 3'd4;
  localparam logic [2:0] MOD_RALT   = 3'd5;
  localparam logic [2:0] MOD_LGUI   = 3'd6;
  localparam logic [2:0] MOD_RGUI   = 3'd7;

  localparam int LOCK_CAPS   = 0;
  localparam int LOCK_NUM    = 1;
  localparam int LOCK_SCROLL = 2;

  // Returns {hit, bit_index} for keys that drive a modifier bit.
  function automatic logic [3:0] mod_lookup(input logic ext, input logic [7:0] code);
    mod_lookup = 4'b0;
    case ({ext, code})
      {1'b0, CODE_SHIFT_L}: mod_lookup = {1'b1, MOD_LSHIFT};
      {1'b0, CODE_SHIFT_R}: mod_lookup = {1'b1, MOD_RSHIFT};
      {1'b0, CODE_CTRL}:    mod_lookup = {1'b1, MOD_LCTRL};
      {1'b1, CODE_CTRL}:    mod_lookup = {1'b1, MOD_RCTRL};
      {1'b0, CODE_ALT}:     mod_lookup = {1'b1, MOD_LALT};
      {1'b1, CODE_ALT}:     mod_lookup = {1'b1, MOD_RALT};
      {1'b1, CODE_GUI_L}:   mod_lookup = {1'b1, MOD_LGUI};
      {1'b1, CODE_GUI_R}:   mod_lookup = {1'b1, MOD_RGUI};
      default:              mod_lookup = 4'b0;
    endcase
  endfunction

  // One-hot toggle mask over {scroll, num, caps}.
  function automatic logic [2:0] lock_lookup(input logic ext, input logic [7:0] code);
    lock_lookup = 3'b0;
    if (code == CODE_CAPS)           lock_lookup[LOCK_CAPS]   = 1'b1;
    if (!ext && code == CODE_NUM)    lock_lookup[LOCK_NUM]    = 1'b1;
    if (!ext && code == CODE_SCROLL) lock_lookup[LOCK_SCROLL] = 1'b1;
  endfunction

endpackage

// File: rtl/ps2_kbd_event_decoder_if.sv
// Byte input from ps2_host and the event output stream of the decoder.
// Handshake: an entry transfers on every clk edge where evt_valid && evt_ready;
// evt_valid/evt_data are held stable until that edge. rx_* are one-cycle strobes.
interface ps2_kbd_event_decoder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;
  logic [9:0] evt_data;
  logic       evt_valid;
  logic       evt_ready;

  modport slave  (input rx_data, rx_valid, rx_error, evt_ready,
                  output evt_data, evt_valid);
  modport master (output rx_data, rx_valid, rx_error, evt_ready,
                  input evt_data, evt_valid);
endinterface

// File: rtl/kbd_event_fifo.sv
// Synchronous FIFO of kbd_event_t; push is accepted when not full or when a
// pop happens on the same edge. Head reads as zero while empty.
module kbd_event_fifo
  import ps2_kbd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  kbd_event_t               push_data,
  input  logic                     pop,
  output kbd_event_t               pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  kbd_event_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/ps2_kbd_event_decoder.sv
// PS/2 Set-2 scan-code parser producing single key events into a FIFO, with
// modifier/lock tracking. Build option: PS2_TYPEMATIC_FILTER_EN drops repeats.
module ps2_kbd_event_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int         FIFO_DEPTH     = 8,
  parameter int         TIMEOUT_CYCLES = 500000,
  parameter logic [7:0] PAUSE_CODE     = 8'hE1
) (
  input  logic                         clk,
  input  logic                         reset,
  ps2_kbd_event_decoder_if.slave       bus,
  output logic [7:0]                   modifiers,
  output logic [2:0]                   locks,
  output logic                         overflow,
  output logic                         seq_error,
  input  logic                         clear_status,
  output parser_state_t                dbg_state,
  output logic [$clog2(FIFO_DEPTH):0]  dbg_fifo_count
);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  parser_state_t    state_q, state_d;
  logic [2:0]       skip_q, skip_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             raw_emit, is_pause, abort;
  kbd_event_t       raw_evt;

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    tmo_d    = tmo_q;
    raw_emit = 1'b0;
    is_pause = 1'b0;
    abort    = 1'b0;
    raw_evt  = '0;
    if (bus.rx_error) begin
      state_d = ST_IDLE;
      skip_d  = '0;
      tmo_d   = '0;
      abort   = (state_q != ST_IDLE);
    end else if (bus.rx_valid) begin
      tmo_d = '0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.rx_data == BYTE_E0)      state_d = ST_GOT_E0;
          else if (bus.rx_data == BYTE_F0) state_d = ST_GOT_F0;
          else if (bus.rx_data == BYTE_E1) begin
            state_d = ST_PAUSE_SKIP;
            skip_d  = 3'd7;
          end else begin
            raw_emit = 1'b1;
            raw_evt  = '{brk: 1'b0, ext: 1'b0, code: bus.rx_data};
          end
        end
        ST_GOT_E0: begin
          if (bus.rx_data == BYTE_F0) state_d = ST_GOT_E0F0;
          else begin
            raw_emit = 1'b1;
            raw_evt  = '{brk: 1'b0, ext: 1'b1, code: bus.rx_data};
            state_d  = ST_IDLE;
          end
        end
        ST_GOT_F0: begin
          raw_emit = 1'b1;
          raw_evt  = '{brk: 1'b1, ext: 1'b0, code: bus.rx_data};
          state_d  = ST_IDLE;
        end
        ST_GOT_E0F0: begin
          raw_emit = 1'b1;
          raw_evt  = '{brk: 1'b1, ext: 1'b1, code: bus.rx_data};
          state_d  = ST_IDLE;
        end
        ST_PAUSE_SKIP: begin
          // The 7 bytes after E1 are swallowed; the last one yields Pause.
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            raw_emit = 1'b1;
            is_pause = 1'b1;
            raw_evt  = '{brk: 1'b0, ext: 1'b1, code: PAUSE_CODE};
            state_d  = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = ST_IDLE;
        skip_d  = '0;
        tmo_d   = '0;
        abort   = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      skip_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      tmo_q   <= tmo_d;
    end
  end

  assign dbg_state = state_q;

  // Extended 12h/59h are the fake-shift wrappers around PrtSc and keypad keys.
  logic key_evt, is_repeat, push, evt_pop, drop, key_side;
  logic fifo_full, fifo_empty;
  logic [3:0] mod_sel;
  kbd_event_t head;

  assign key_evt = raw_emit && !(raw_evt.ext &&
                   (raw_evt.code == CODE_SHIFT_L || raw_evt.code == CODE_SHIFT_R));

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [511:0] held_q;
  // Pause never breaks, so it stays out of the held map.
  assign is_repeat = !raw_evt.brk && !is_pause && held_q[{raw_evt.ext, raw_evt.code}];
  always_ff @(posedge clk) begin
    if (reset) held_q <= '0;
    else if (key_evt && !is_pause) held_q[{raw_evt.ext, raw_evt.code}] <= !raw_evt.brk;
  end
`else
  assign is_repeat = 1'b0;
`endif

  assign push     = key_evt && !is_repeat;
  assign key_side = key_evt && !is_pause;
  assign mod_sel  = mod_lookup(raw_evt.ext, raw_evt.code);
  assign evt_pop  = bus.evt_valid && bus.evt_ready;
  assign drop     = push && fifo_full && !evt_pop;

  kbd_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (raw_evt),
    .pop       (bus.evt_ready),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (dbg_fifo_count)
  );

  assign bus.evt_valid = !fifo_empty;
  assign bus.evt_data  = head;

  always_ff @(posedge clk) begin
    if (reset) begin
      modifiers <= '0;
      locks     <= '0;
      overflow  <= 1'b0;
      seq_error <= 1'b0;
    end else begin
      if (key_side && mod_sel[3]) modifiers[mod_sel[2:0]] <= !raw_evt.brk;
      if (key_side && push && !raw_evt.brk)
        locks <= locks ^ lock_lookup(raw_evt.ext, raw_evt.code);
      if (drop)              overflow <= 1'b1;
      else if (clear_status) overflow <= 1'b0;
      if (abort)             seq_error <= 1'b1;
      else if (clear_status) seq_error <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ps2_kbd_event_decoder.sv
// Self-checking bench for ps2_kbd_event_decoder: directed sequences with
// literal expectations plus random byte streams against a queue-based model.
module tb_ps2_kbd_event_decoder;
  import ps2_kbd_pkg::*;

  localparam int         DEPTH = 8;
  localparam int         TMO   = 40;
  localparam logic [7:0] PAUSE = 8'hE1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear_status = 1'b0;
  logic [7:0] modifiers;
  logic [2:0] locks;
  logic overflow, seq_error;
  parser_state_t dbg_state;
  logic [$clog2(DEPTH):0] dbg_fifo_count;

  ps2_kbd_event_decoder_if bus();

  ps2_kbd_event_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .PAUSE_CODE(PAUSE)) dut (
    .clk(clk), .reset(reset), .bus(bus), .modifiers(modifiers), .locks(locks),
    .overflow(overflow), .seq_error(seq_error), .clear_status(clear_status),
    .dbg_state(dbg_state), .dbg_fifo_count(dbg_fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]   seq[$];
  logic [9:0]   exp_q[$];
  int           quiet;
  logic [7:0]   m_mods;
  logic [2:0]   m_locks;
  logic         m_ovf, m_err;
  logic [511:0] m_held;
  logic         m_have, m_pause, m_push, m_pop, m_set_ovf, m_set_err, m_mk;
  logic [9:0]   m_ev;

  always @(posedge clk) begin
    if (reset) begin
      seq.delete(); exp_q.delete(); quiet = 0;
      m_mods = '0; m_locks = '0; m_ovf = 1'b0; m_err = 1'b0; m_held = '0;
    end else begin
      m_have = 1'b0; m_pause = 1'b0; m_set_ovf = 1'b0; m_set_err = 1'b0; m_ev = '0;
      m_pop = (exp_q.size() != 0) && bus.evt_ready;
      if (bus.rx_error) begin
        m_set_err = (seq.size() != 0);
        seq.delete(); quiet = 0;
      end else if (bus.rx_valid) begin
        quiet = 0;
        seq.push_back(bus.rx_data);
        if (seq[0] == 8'hE1) begin
          if (seq.size() == 8) begin
            m_have = 1'b1; m_pause = 1'b1; m_ev = {2'b01, PAUSE}; seq.delete();
          end
        end else if (!(seq.size() == 1 && (seq[0] == 8'hE0 || seq[0] == 8'hF0)) &&
                     !(seq.size() == 2 && seq[0] == 8'hE0 && seq[1] == 8'hF0)) begin
          m_have = 1'b1;
          m_ev[9] = (seq.size() > 1) && (seq[seq.size()-2] == 8'hF0);
          m_ev[8] = (seq[0] == 8'hE0);
          m_ev[7:0] = seq[seq.size()-1];
          seq.delete();
        end
      end else if (seq.size() != 0) begin
        quiet++;
        if (quiet == TMO) begin m_set_err = 1'b1; seq.delete(); quiet = 0; end
      end
      if (m_have && m_ev[8] && (m_ev[7:0] == 8'h12 || m_ev[7:0] == 8'h59)) m_have = 1'b0;
      if (m_pop) void'(exp_q.pop_front());
      if (m_have) begin
        m_mk = !m_ev[9];
        m_push = 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
        if (!m_pause) begin
          if (m_mk && m_held[m_ev[8:0]]) m_push = 1'b0;
          m_held[m_ev[8:0]] = m_mk;
        end
`endif
        if (m_push) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(m_ev);
          else m_set_ovf = 1'b1;
        end
        if (!m_pause) begin
          case (m_ev[8:0])
            9'h012: m_mods[0] = m_mk;
            9'h059: m_mods[1] = m_mk;
            9'h014: m_mods[2] = m_mk;
            9'h114: m_mods[3] = m_mk;
            9'h011: m_mods[4] = m_mk;
            9'h111: m_mods[5] = m_mk;
            9'h11F: m_mods[6] = m_mk;
            9'h127: m_mods[7] = m_mk;
            default: ;
          endcase
          if (m_push && m_mk) begin
            if (m_ev[7:0] == 8'h58) m_locks[0] = ~m_locks[0];
            if (m_ev[8:0] == 9'h077) m_locks[1] = ~m_locks[1];
            if (m_ev[8:0] == 9'h07E) m_locks[2] = ~m_locks[2];
          end
        end
      end
      if (m_set_ovf) m_ovf = 1'b1; else if (clear_status) m_ovf = 1'b0;
      if (m_set_err) m_err = 1'b1; else if (clear_status) m_err = 1'b0;
    end
  end

  // ---------------- scoreboard compare ----------------
  logic [9:0] pop_log[$];
  logic [9:0] want_q[$];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("evt_valid", 32'(bus.evt_valid), 32'(exp_q.size() != 0));
      chk("evt_data", 32'(bus.evt_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
      chk("fifo_count", 32'(dbg_fifo_count), 32'(exp_q.size()));
      chk("modifiers", 32'(modifiers), 32'(m_mods));
      chk("locks", 32'(locks), 32'(m_locks));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("seq_error", 32'(seq_error), 32'(m_err));
      if (bus.evt_valid === 1'b1 && bus.evt_ready === 1'b1) pop_log.push_back(bus.evt_data);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input logic [7:0] d, input logic e);
    bus.rx_valid = v; bus.rx_data = d; bus.rx_error = e;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0; bus.rx_error = 1'b0; clear_status = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic chk_log(input string name);
    chk({name, "_n"}, 32'(pop_log.size()), 32'(want_q.size()));
    for (int i = 0; i < want_q.size() && i < pop_log.size(); i++) chk(name, 32'(pop_log[i]), 32'(want_q[i]));
    pop_log.delete();
  endtask

  function automatic logic [7:0] pick_byte();
    case ($urandom_range(0, 11))
      0: pick_byte = 8'hE0;
      1: pick_byte = 8'hF0;
      2: pick_byte = 8'hE1;
      3: pick_byte = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
      4: pick_byte = ($urandom_range(0, 1) != 0) ? 8'h14 : 8'h11;
      5: pick_byte = ($urandom_range(0, 1) != 0) ? 8'h1F : 8'h27;
      6: pick_byte = 8'h58;
      7: pick_byte = ($urandom_range(0, 1) != 0) ? 8'h77 : 8'h7E;
      default: pick_byte = 8'($urandom_range(0, 255));
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.rx_error = 1'b0; bus.evt_ready = 1'b1;
    @(posedge clk); chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_evt_valid", 32'(bus.evt_valid), 32'h0);
    chk("rst_evt_data", 32'(bus.evt_data), 32'h0);
    chk("rst_modifiers", 32'(modifiers), 32'h0);
    chk("rst_locks", 32'(locks), 32'h0);
    chk("rst_flags", 32'({overflow, seq_error}), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // Make then break; evt_valid one cycle after the final byte.
    send(8'h1C);
    chk("make_latency", 32'({bus.evt_valid, bus.evt_data}), 32'h41C);
    send(8'hF0); send(8'h1C);
    chk("break_latency", 32'({bus.evt_valid, bus.evt_data}), 32'h61C);
    idle(2);
    want_q = '{10'h01C, 10'h21C}; chk_log("make_break");

    send(8'hE0); send(8'h14);
    chk("rctrl_on", 32'(modifiers), 32'h08);
    send(8'hE0); send(8'hF0); send(8'h14);
    chk("rctrl_off", 32'(modifiers), 32'h00);
    idle(2);
    want_q = '{10'h114, 10'h314}; chk_log("ext");

    foreach (want_q[i]) ;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    idle(2);
    chk("pause_locks", 32'(locks), 32'h0);
    want_q = '{10'h1E1}; chk_log("pause");

    send(8'h58); send(8'hF0); send(8'h58);
    idle(2);
    chk("caps_on", 32'(locks), 32'h1);
    want_q = '{10'h058, 10'h258}; chk_log("caps");

`ifdef PS2_TYPEMATIC_FILTER_EN
    send(8'h58); send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
    idle(2);
    chk("typematic_caps", 32'(locks), 32'h0);
    want_q = '{10'h058, 10'h258}; chk_log("typematic");
`endif

    // Fill with consumer stalled, one beyond capacity.
    bus.evt_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(8'h15 + 8'(i));
    chk("ovf_set", 32'(overflow), 32'h1);
    chk("ovf_count", 32'(dbg_fifo_count), 32'd8);
    clear_status = 1'b1; idle(1);
    chk("ovf_clear", 32'(overflow), 32'h0);
    bus.evt_ready = 1'b1; idle(10);
    want_q = '{10'h015, 10'h016, 10'h017, 10'h018, 10'h019, 10'h01A, 10'h01B, 10'h01C};
    chk_log("drain");

    // Timeout boundary: one cycle short must not abort.
    send(8'hE0); idle(TMO - 1);
    chk("tmo_early", 32'(seq_error), 32'h0);
    idle(1);
    chk("tmo_fire", 32'(seq_error), 32'h1);
    chk("tmo_no_evt", 32'(bus.evt_valid), 32'h0);
    clear_status = 1'b1; idle(1);
    chk("err_clear", 32'(seq_error), 32'h0);

    send(8'hE0); step(1'b0, 8'h00, 1'b1);
    chk("rxerr_abort", 32'(seq_error), 32'h1);
    send(8'h1C); idle(2);
    want_q = '{10'h01C}; chk_log("after_error");

    clear_status = 1'b1; idle(1);
    send(8'hE0); step(1'b1, 8'h2A, 1'b1); send(8'h2A); idle(2);
    chk("err_wins", 32'(seq_error), 32'h1);
    want_q = '{10'h02A}; chk_log("err_and_valid");

    send(8'hE0);
    reset = 1'b1; idle(1); reset = 1'b0;
    send(8'h1C); idle(2);
    want_q = '{10'h01C}; chk_log("reset_mid_seq");

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 2000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      bus.evt_ready = ($urandom_range(0, 3) != 0);
      clear_status = ($urandom_range(0, 29) == 0);
      if (r < 3)       step(1'b0, 8'h00, 1'b1);
      else if (r < 5)  step(1'b1, pick_byte(), 1'b1);
      else if (r < 7)  idle(TMO - 1 + $urandom_range(0, 2));
      else if (r < 12) begin bus.evt_ready = 1'b0; idle($urandom_range(1, 4)); end
      else if (r < 75) send(pick_byte());
      else             idle($urandom_range(1, 2));
    end
    bus.evt_ready = 1'b1;
    idle(DEPTH + 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
